// File: rtl/ace_pc_pkg.sv
// Shared encodings and helpers for the fetch program counter.
package ace_pc_pkg;

  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned PC_SELECT_WIDTH = 2;

  // Next-PC multiplexor select: in0..in3 of multiplexor_4x1.
  typedef enum logic [PC_SELECT_WIDTH-1:0] {
    PC_SELECT_SEQUENTIAL = 2'b00,
    PC_SELECT_BRANCH     = 2'b01,
    PC_SELECT_JUMP       = 2'b10,
    PC_SELECT_VECTOR     = 2'b11
  } pc_select_t;

  typedef enum logic {
    PC_STATE_RESET_WAIT = 1'b0,
    PC_STATE_FETCH      = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    PENDING_NONE      = 2'b00,
    PENDING_BRANCH    = 2'b01,
    PENDING_JUMP      = 2'b10,
    PENDING_EXCEPTION = 2'b11
  } pending_kind_t;

  // A redirect request: its kind and word-aligned destination.
  typedef struct packed {
    pending_kind_t         kind;
    logic [PC_WIDTH-1:0]   target;
  } pending_t;

  localparam pending_t PENDING_CLEAR = '{kind: PENDING_NONE, target: '0};

  // Instruction addresses are word aligned; drop the low two bits.
  function automatic logic [PC_WIDTH-1:0] align_target(input logic [PC_WIDTH-1:0] target);
    return {target[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/multiplexor_4x1.sv
// Four-input next-PC selector; 32-bit datapath only.
module multiplexor_4x1
  import ace_pc_pkg::*;
(
  input  logic [PC_SELECT_WIDTH-1:0] select,
  input  logic [PC_WIDTH-1:0]        in0,
  input  logic [PC_WIDTH-1:0]        in1,
  input  logic [PC_WIDTH-1:0]        in2,
  input  logic [PC_WIDTH-1:0]        in3,
  output logic [PC_WIDTH-1:0]        out_c
);

  // Route the selected input to the output.
  always_comb begin
    out_c = in0;
    case (select)
      PC_SELECT_BRANCH: out_c = in1;
      PC_SELECT_JUMP:   out_c = in2;
      PC_SELECT_VECTOR: out_c = in3;
      default:          out_c = in0;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Fetch program counter: issues addresses over valid/ready and retains
// one redirect that arrives while the fetch is stalled.
module program_counter
  import ace_pc_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH        = PC_WIDTH,
  parameter logic [BIT_WIDTH-1:0] RESET_VECTOR     = 32'hBFC0_0000,
  parameter logic [BIT_WIDTH-1:0] EXCEPTION_VECTOR = 32'h8000_0180
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [BIT_WIDTH-1:0] fetch_address,
  input  logic                 branch_taken,
  input  logic [BIT_WIDTH-1:0] branch_target,
  input  logic                 jump,
  input  logic [BIT_WIDTH-1:0] jump_target,
  input  logic                 exception,
  output logic                 redirect_pending
);

  pc_state_t            state_q, state_d;
  pending_t             pending_q, pending_d;
  logic                 valid_d;
  logic                 redirect_pending_d;
  logic [BIT_WIDTH-1:0] address_d;

  pending_t             request_c;
  logic                 request_wins_c;
  pc_select_t           select_c;
  logic [BIT_WIDTH-1:0] sequential_c;
  logic [BIT_WIDTH-1:0] branch_aligned_c;
  logic [BIT_WIDTH-1:0] jump_aligned_c;
  logic [BIT_WIDTH-1:0] vector_target_c;
  logic [BIT_WIDTH-1:0] next_pc_c;

  assign sequential_c     = fetch_address + BIT_WIDTH'(4);
  assign branch_aligned_c = align_target(branch_target);
  assign jump_aligned_c   = align_target(jump_target);

  // Collapse this cycle's redirect inputs to one request by priority, and
  // decide whether it may displace what is already pending.
  always_comb begin
    request_c = PENDING_CLEAR;
    if (exception) begin
      request_c = '{kind: PENDING_EXCEPTION, target: align_target(EXCEPTION_VECTOR)};
    end else if (branch_taken) begin
      request_c = '{kind: PENDING_BRANCH, target: branch_aligned_c};
    end else if (jump) begin
      request_c = '{kind: PENDING_JUMP, target: jump_aligned_c};
    end
    request_wins_c = (request_c.kind != PENDING_NONE) &&
                     !((pending_q.kind == PENDING_EXCEPTION) &&
                       (request_c.kind != PENDING_EXCEPTION));
  end

  // in3 carries the exception vector when one is requested now, else the pending target.
  assign vector_target_c = (request_c.kind == PENDING_EXCEPTION) ? request_c.target
                                                                  : pending_q.target;

  // Next-PC select: winning live redirect, then pending target, then PC+4.
  always_comb begin
    select_c = PC_SELECT_SEQUENTIAL;
    if (request_wins_c) begin
      case (request_c.kind)
        PENDING_EXCEPTION: select_c = PC_SELECT_VECTOR;
        PENDING_BRANCH:    select_c = PC_SELECT_BRANCH;
        PENDING_JUMP:      select_c = PC_SELECT_JUMP;
        default:           select_c = PC_SELECT_SEQUENTIAL;
      endcase
    end else if (pending_q.kind != PENDING_NONE) begin
      select_c = PC_SELECT_VECTOR;
    end
  end

  multiplexor_4x1 next_pc_multiplexor (
    .select (select_c),
    .in0    (sequential_c),
    .in1    (branch_aligned_c),
    .in2    (jump_aligned_c),
    .in3    (vector_target_c),
    .out_c  (next_pc_c)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PC_STATE_RESET_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, PC advance on handshake, redirect capture while stalled.
  always_comb begin
    state_d            = state_q;
    valid_d            = fetch_valid;
    address_d          = fetch_address;
    pending_d          = pending_q;
    redirect_pending_d = redirect_pending;
    case (state_q)
      PC_STATE_RESET_WAIT: begin
        state_d = PC_STATE_FETCH;
        valid_d = 1'b1;
      end
      PC_STATE_FETCH: begin
        valid_d = 1'b1;
        if (fetch_valid && fetch_ready) begin
          address_d          = next_pc_c;
          pending_d          = PENDING_CLEAR;
          redirect_pending_d = 1'b0;
        end else if (request_wins_c) begin
          pending_d          = request_c;
          redirect_pending_d = 1'b1;
        end
      end
      default: state_d = PC_STATE_RESET_WAIT;
    endcase
  end

  // Output and pending registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid      <= 1'b0;
      fetch_address    <= RESET_VECTOR;
      pending_q        <= PENDING_CLEAR;
      redirect_pending <= 1'b0;
    end else begin
      fetch_valid      <= valid_d;
      fetch_address    <= address_d;
      pending_q        <= pending_d;
      redirect_pending <= redirect_pending_d;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a cycle-level reference model.
module tb_program_counter;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'h8000_0180;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_address;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic        redirect_pending;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  program_counter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .fetch_address    (fetch_address),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .exception        (exception),
    .redirect_pending (redirect_pending)
  );

  always #5 clock = ~clock;

  // Reference model: running flag, PC, and at most one retained redirect.
  logic        m_run;
  logic [31:0] m_addr;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        m_pend_exc;

  always @(posedge clock or negedge reset_n) begin : model
    logic        has_req;
    logic [31:0] req_tgt;
    logic        take;
    if (!reset_n) begin
      m_run      <= 1'b0;
      m_addr     <= RV;
      m_pend     <= 1'b0;
      m_pend_tgt <= 32'h0;
      m_pend_exc <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else begin
      has_req = exception || branch_taken || jump;
      if (exception)         req_tgt = EV;
      else if (branch_taken) req_tgt = branch_target & ~32'h3;
      else                   req_tgt = jump_target & ~32'h3;
      take = has_req && !(m_pend && m_pend_exc && !exception);
      if (fetch_ready) begin
        if (take)        m_addr <= req_tgt;
        else if (m_pend) m_addr <= m_pend_tgt;
        else             m_addr <= m_addr + 32'd4;
        m_pend <= 1'b0;
      end else if (take) begin
        m_pend     <= 1'b1;
        m_pend_tgt <= req_tgt;
        m_pend_exc <= exception;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clock) begin
    check("model_valid", 32'(fetch_valid), 32'(m_run));
    check("model_address", fetch_address, m_addr);
    check("model_pending", 32'(redirect_pending), 32'(m_pend));
  end

  // Apply one cycle of inputs, then land just after the next rising edge.
  task automatic step(input logic rdy, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic ex);
    fetch_ready   = rdy;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    exception     = ex;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #4;
    check("reset_valid", 32'(fetch_valid), 32'h0);
    check("reset_address", fetch_address, RV);
    check("reset_pending", 32'(redirect_pending), 32'h0);
    reset_n = 1'b1;

    // Sequential fetch from the reset vector.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("first_valid", 32'(fetch_valid), 32'h1);
    check("first_address", fetch_address, 32'hBFC0_0000);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("seq_1", fetch_address, 32'hBFC0_0004);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("seq_2", fetch_address, 32'hBFC0_0008);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("seq_3", fetch_address, 32'hBFC0_000C);

    // Branch on a handshake cycle, misaligned target.
    step(1'b1, 1'b1, 32'h0000_1003, 1'b0, 32'h0, 1'b0);
    check("branch_hs", fetch_address, 32'h0000_1000);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("branch_plus4", fetch_address, 32'h0000_1004);

    // Jump while stalled is held until the handshake.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2000, 1'b0);
    check("stall_hold", fetch_address, 32'h0000_1004);
    check("stall_pending", 32'(redirect_pending), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("stall_hold2", fetch_address, 32'h0000_1004);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("jump_released", fetch_address, 32'h0000_2000);
    check("jump_pending_clr", 32'(redirect_pending), 32'h0);

    // Pending exception is not displaced by a later branch.
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0);
    check("exc_hold", fetch_address, 32'h0000_2000);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("exc_wins", fetch_address, EV);
    check("exc_pending_clr", 32'(redirect_pending), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("exc_plus4", fetch_address, 32'h8000_0184);

    // All three redirects together on a handshake.
    step(1'b1, 1'b1, 32'h0000_4000, 1'b1, 32'h0000_5000, 1'b1);
    check("priority_all", fetch_address, EV);

    // Live jump beats a pending branch on the handshake.
    step(1'b0, 1'b1, 32'h0000_6000, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_7000, 1'b0);
    check("live_over_pend", fetch_address, 32'h0000_7000);

    // Pending exception beats a live branch on the handshake.
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0);
    check("pend_exc_over_live", fetch_address, EV);

    // Later branch overwrites a pending jump.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("overwrite", fetch_address, 32'h0000_0200);

    // Wrap at the top of the address space.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    check("wrap_pre", fetch_address, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("wrap", fetch_address, 32'h0000_0000);

    // Reset during a pending stall clears state at once.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_8000, 1'b0);
    check("pre_reset_pending", 32'(redirect_pending), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_address", fetch_address, RV);
    check("async_pending", 32'(redirect_pending), 32'h0);
    check("async_valid", 32'(fetch_valid), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Redirect during the reset-wait cycle is ignored.
    step(1'b1, 1'b1, 32'h0000_9000, 1'b0, 32'h0, 1'b0);
    check("rewait_address", fetch_address, RV);
    check("rewait_valid", 32'(fetch_valid), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rewait_next", fetch_address, 32'hBFC0_0004);
    check("rewait_pending", 32'(redirect_pending), 32'h0);

    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Holds the fetch address and produces the next instruction address for the front end, issuing it to instruction memory over a valid/ready handshake. Sits directly upstream of the next-PC `multiplexor_4x1`: it drives that mux's 2-bit select and consumes its output as the new PC. It captures branch, jump and exception redirects that arrive while a fetch is stalled, so no redirect is lost.

## Interface
- `BIT_WIDTH`, 32, address width; only 32 is supported by `multiplexor_4x1`.
- `RESET_VECTOR`, 32'hBFC0_0000, first fetch address after reset.
- `EXCEPTION_VECTOR`, 32'h8000_0180, target on `exception`.

- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  out  1  `fetch_address` is a live request.
- `fetch_ready`  in  1  instruction memory accepts the request this cycle.
- `fetch_address`  out  BIT_WIDTH  current PC, registered.
- `branch_taken`  in  1  single-cycle pulse; redirect to `branch_target`.
- `branch_target`  in  BIT_WIDTH  branch destination.
- `jump`  in  1  single-cycle pulse; redirect to `jump_target`.
- `jump_target`  in  BIT_WIDTH  jump destination.
- `exception`  in  1  single-cycle pulse; redirect to `EXCEPTION_VECTOR`.
- `redirect_pending`  out  1  a captured redirect awaits the next handshake.

## Operation
- **States:** RESET_WAIT and FETCH.
  - Reset forces RESET_WAIT, `fetch_valid`=0, `fetch_address`=RESET_VECTOR and `redirect_pending`=0. The pending target register is cleared and the pending kind is NONE.
  - RESET_WAIT -> FETCH on the first edge after reset release. FETCH has no exit except reset.
  - In FETCH, `fetch_valid`=1 continuously.
- **Redirect priority within one cycle:** exception > branch_taken > jump.
- **Mux select encoding:**
  - 00 = PC+4 (in0).
  - 01 = branch target (in1).
  - 10 = jump target (in2).
  - 11 = exception vector or pending target (in3).
- **Handshake edge** (`fetch_valid && fetch_ready`), next PC is chosen in this order:
  - A redirect input this cycle wins, unless a pending EXCEPTION exists and the input is not an exception.
  - Otherwise the pending target, if any.
  - Otherwise PC+4.
  - Pending is cleared.
- **No handshake:**
  - `fetch_address` is held stable.
  - A redirect input is captured into the pending register and `redirect_pending` is set.
  - A new redirect overwrites the pending one unless the pending kind is EXCEPTION and the new one is not.
  - An exception always overwrites.
- **Arithmetic:**
  - PC+4 is modulo 2^BIT_WIDTH, so 32'hFFFF_FFFC wraps to 0.
  - Bits [1:0] of every target are forced to 00 before use.
- Redirect pulses during RESET_WAIT are ignored.

## Timing
- First request: `fetch_valid`=1 with RESET_VECTOR one edge after `reset_n` rises.
- Throughput is one address per cycle while `fetch_ready`=1.
- Redirect latency:
  - Target appears on `fetch_address` the edge after the redirect cycle, if that cycle completed a handshake.
  - Otherwise it appears the edge after the handshake completes.
- `redirect_pending` is registered: it rises the edge after capture and falls on the consuming handshake edge.
- Holding `fetch_ready`=0 indefinitely keeps the address stable; at most one redirect is retained.
- Asserting `reset_n` low mid-stall discards pending state immediately (asynchronous).

## Structure
- Shared package `ace_pc_pkg` holds:
  - Select encodings `PC_SELECT_SEQUENTIAL`, `PC_SELECT_BRANCH`, `PC_SELECT_JUMP`, `PC_SELECT_VECTOR`.
  - State encodings `PC_STATE_RESET_WAIT`, `PC_STATE_FETCH`.
  - Pending-kind encodings NONE, BRANCH, JUMP, EXCEPTION.
- One sub-module: `multiplexor_4x1` instance `next_pc_multiplexor`.
  - in0 = PC+4, in1 = branch target, in2 = jump target, in3 = vector/pending target.
  - Select is driven by this block's priority logic.
- The PC register, pending registers and FSM live in this module.

## Test plan
- Reset release with `fetch_ready`=1 for 4 cycles -> addresses BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C; `fetch_valid`=0 in the first cycle after release only.
- `branch_taken` with target 0000_1003 in a handshake cycle -> next address 0000_1000, then 0000_1004.
- `fetch_ready`=0, pulse `jump` with target 0000_2000 -> address held, `redirect_pending`=1 next cycle; raise `fetch_ready` -> 0000_2000 issued, `redirect_pending`=0.
- While stalled: `exception`, then `branch_taken` with target 0000_3000 two cycles later -> after the handshake, 8000_0180 is issued, not 0000_3000.
- Same-cycle `exception`, `branch_taken` and `jump` with handshake -> 8000_0180.
- PC at FFFF_FFFC with handshake -> 0000_0000; `reset_n` low during a pending stall -> BFC0_0000, `redirect_pending`=0 immediately.
